// File: rtl/board_pkg.sv
// board_pkg: FSM state type, scan-length bound and cell helpers shared by the board engine.
package board_pkg;
  typedef enum logic [2:0] {IDLE, APPLY, CHECK, DONE, WON} state_t;
  localparam int MAX_N = 8;
  localparam int CHECK_LEN_MAX = MAX_N * MAX_N - 1;
  function automatic int cell_lsb(int r, int c, int n, int sw);
    return (r * n + c) * sw;
  endfunction
  function automatic int step_cell(int v, logic dec, int nstates);
    return dec ? ((v == 0) ? nstates - 1 : v - 1) : ((v == nstates - 1) ? 0 : v + 1);
  endfunction
endpackage

// File: rtl/board_if.sv
// board_if: switch/button controls in, board image and status out.
// The add_n signal exists only when BOARD_DECREMENT_EN is defined.
interface board_if #(parameter int N = 4, parameter int SW = 2, parameter int MOVE_W = 8);
  logic fire;
  logic [N-1:0] sel;
  logic n_row;
  logic load_en;
  logic [N*N*SW-1:0] load_data;
  logic [N*N*SW-1:0] board;
  logic error;
  logic busy;
  logic win;
  logic [MOVE_W-1:0] move_count;
`ifdef BOARD_DECREMENT_EN
  logic add_n;
  modport master(output fire, sel, n_row, load_en, load_data, add_n, input board, error, busy, win, move_count);
  modport slave(input fire, sel, n_row, load_en, load_data, add_n, output board, error, busy, win, move_count);
`else
  modport master(output fire, sel, n_row, load_en, load_data, input board, error, busy, win, move_count);
  modport slave(input fire, sel, n_row, load_en, load_data, output board, error, busy, win, move_count);
`endif
endinterface

// File: rtl/board_win_scanner.sv
// board_win_scanner: after a move, walks cells 1..N*N-1 one per cycle and ANDs equality with cell 0.
module board_win_scanner import board_pkg::*; #(
  parameter int N = 4,
  parameter int SW = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [N*N*SW-1:0] cells,
  output logic done,
  output logic eq
);
  localparam int CHECK_LEN = N * N - 1;
  localparam int KW = $clog2(CHECK_LEN_MAX + 1);
  logic [KW-1:0] k;
  logic active;
  logic match;
  assign match = cells[int'(k)*SW +: SW] == cells[SW-1:0];
  assign done = active && (k == KW'(CHECK_LEN));
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      k <= '0;
      active <= 1'b0;
      eq <= 1'b0;
    end else if (start) begin
      k <= KW'(1);
      active <= 1'b1;
      eq <= 1'b1;
    end else if (active) begin
      eq <= eq & match;
      k <= k + KW'(1);
      active <= !done;
    end
endmodule

// File: rtl/board_engine.sv
// board_engine: N x N cell board; a fire edge steps one row/column, then a sequential win scan runs.
// Define BOARD_DECREMENT_EN to add add_n, which makes a move step the selected cells downward.
module board_engine import board_pkg::*; #(
  parameter int N = 4,
  parameter int SW = 2,
  parameter int NSTATES = 4,
  parameter int MOVE_W = 8
) (
  input logic clk,
  input logic reset,
  board_if.slave bus
);
  localparam int IW = $clog2(N);
  logic [N*N*SW-1:0] cells, load_clean;
  state_t state;
  logic fire_q, fire_edge, dec_q, n_row_q, busy_r, win_r, start, scan_done, eq;
  logic [N-1:0] sel_q;
  logic [IW-1:0] idx, line;
  logic [MOVE_W-1:0] move_count;
  logic [SW-1:0] cur, nxt;
  int lsb;
  assign bus.error = !(bus.sel != '0 && (bus.sel & (bus.sel - N'(1))) == '0);
  assign bus.board = cells;
  assign bus.busy = busy_r;
  assign bus.win = win_r;
  assign bus.move_count = move_count;
  assign fire_edge = bus.fire & ~fire_q;
  assign start = (state == APPLY) && (idx == IW'(N - 1));
  always_comb begin
    line = '0;
    for (int i = 0; i < N; i++) line = sel_q[i] ? IW'(i) : line;
  end
  // n_row=0 walks across the selected row, n_row=1 walks down the selected column
  assign lsb = n_row_q ? cell_lsb(int'(idx), int'(line), N, SW) : cell_lsb(int'(line), int'(idx), N, SW);
  assign cur = cells[lsb +: SW];
  assign nxt = SW'(step_cell(int'(cur), dec_q, NSTATES));
  for (genvar g = 0; g < N * N; g++) begin : g_load
    assign load_clean[g*SW +: SW] = (int'(bus.load_data[g*SW +: SW]) >= NSTATES) ? '0 : bus.load_data[g*SW +: SW];
  end
`ifndef BOARD_DECREMENT_EN
  assign dec_q = 1'b0;
`endif
  board_win_scanner #(.N(N), .SW(SW)) u_scan (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cells(cells),
    .done(scan_done),
    .eq(eq)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cells <= '0;
      move_count <= '0;
      win_r <= 1'b0;
      busy_r <= 1'b0;
      fire_q <= 1'b0;
      idx <= '0;
      sel_q <= '0;
      n_row_q <= 1'b0;
`ifdef BOARD_DECREMENT_EN
      dec_q <= 1'b0;
`endif
      state <= IDLE;
    end else begin
      fire_q <= bus.fire;
      case (state)
        IDLE, WON:
          if (bus.load_en) begin
            cells <= load_clean;
            move_count <= '0;
            win_r <= 1'b0;
            state <= IDLE;
          end else if (state == IDLE && fire_edge && !bus.error) begin
            sel_q <= bus.sel;
            n_row_q <= bus.n_row;
`ifdef BOARD_DECREMENT_EN
            dec_q <= bus.add_n;
`endif
            idx <= '0;
            move_count <= (move_count == '1) ? move_count : move_count + MOVE_W'(1);
            busy_r <= 1'b1;
            state <= APPLY;
          end
        APPLY: begin
          cells[lsb +: SW] <= nxt;
          idx <= idx + IW'(1);
          if (start) state <= CHECK;
        end
        CHECK: if (scan_done) state <= DONE;
        DONE: begin
          win_r <= eq;
          busy_r <= 1'b0;
          state <= eq ? WON : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_board_engine.sv
// tb_board_engine: table-driven and scoreboard checks of board_engine, with a second NSTATES=3 instance for load clipping.
module tb_board_engine;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  board_if #(.N(4), .SW(2), .MOVE_W(8)) bus4();
  board_if #(.N(4), .SW(2), .MOVE_W(8)) bus3();
  board_engine #(.N(4), .SW(2), .NSTATES(4), .MOVE_W(8)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
  board_engine #(.N(4), .SW(2), .NSTATES(3), .MOVE_W(8)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

  typedef struct { logic [31:0] board; logic [7:0] mc; logic win; int busy; } exp_t;
  typedef struct { logic [3:0] sel; logic err; } err_vec_t;
  typedef struct { logic [3:0] sel; logic n_row; int hold; int poke; } move_vec_t;

  exp_t sb[$];
  int m[16];
  logic [7:0] mc;
  logic won;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack();
    logic [31:0] p = '0;
    for (int i = 0; i < 16; i++) p[i*2 +: 2] = 2'(m[i]);
    return p;
  endfunction

  task automatic do_load(input logic [31:0] d);
    @(negedge clk);
    bus4.load_en = 1'b1;
    bus4.load_data = d;
    @(negedge clk);
    bus4.load_en = 1'b0;
    for (int i = 0; i < 16; i++) m[i] = int'(d[i*2 +: 2]);
    mc = 8'd0;
    won = 1'b0;
    check("load_board", bus4.board, pack());
    check("load_move_count", 32'(bus4.move_count), 32'(mc));
    check("load_win", 32'(bus4.win), 32'(won));
  endtask

  // hold: cycles fire stays high; poke: cycle at which a second one-cycle fire pulse is sent
  task automatic do_move(input logic [3:0] s, input logic nr, input int hold, input int poke);
    exp_t e;
    exp_t got;
    int bc;
    int ln;
    bc = 0;
    if (!won && $countones(s) == 1) begin
      ln = 0;
      for (int i = 0; i < 4; i++) if (s[i]) ln = i;
      for (int i = 0; i < 4; i++) begin
        int a;
        a = nr ? i * 4 + ln : ln * 4 + i;
        m[a] = (m[a] == 3) ? 0 : m[a] + 1;
      end
      mc = (mc == 8'hff) ? mc : mc + 8'd1;
      won = 1'b1;
      for (int i = 1; i < 16; i++) if (m[i] != m[0]) won = 1'b0;
      e.busy = 20;
    end else e.busy = 0;
    e.board = pack();
    e.mc = mc;
    e.win = won;
    sb.push_back(e);
    @(negedge clk);
    bus4.sel = s;
    bus4.n_row = nr;
    bus4.fire = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      bus4.fire = (i < hold) || (i == poke);
      if (bus4.busy) bc++;
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
    end else begin
      got = sb.pop_front();
      check("busy_len", 32'(bc), 32'(got.busy));
      check("move_board", bus4.board, got.board);
      check("move_count", 32'(bus4.move_count), 32'(got.mc));
      check("move_win", 32'(bus4.win), 32'(got.win));
    end
  endtask

  initial begin
    err_vec_t ev[6];
    move_vec_t mv[5];
    logic [31:0] d;
    int bc;
    ev[0] = '{4'b0000, 1'b1};
    ev[1] = '{4'b0110, 1'b1};
    ev[2] = '{4'b0001, 1'b0};
    ev[3] = '{4'b1000, 1'b0};
    ev[4] = '{4'b1111, 1'b1};
    ev[5] = '{4'b0100, 1'b0};
    mv[0] = '{4'b0110, 1'b0, 1, 0};
    mv[1] = '{4'b0010, 1'b0, 10, 0};
    mv[2] = '{4'b0001, 1'b1, 1, 5};
    mv[3] = '{4'b0000, 1'b0, 1, 0};
    mv[4] = '{4'b1000, 1'b0, 1, 0};
    bus4.fire = 1'b0; bus4.sel = '0; bus4.n_row = 1'b0; bus4.load_en = 1'b0; bus4.load_data = '0;
    bus3.fire = 1'b0; bus3.sel = '0; bus3.n_row = 1'b0; bus3.load_en = 1'b0; bus3.load_data = '0;
`ifdef BOARD_DECREMENT_EN
    bus4.add_n = 1'b0;
    bus3.add_n = 1'b0;
`endif
    for (int i = 0; i < 16; i++) m[i] = 0;
    mc = 8'd0;
    won = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_board", bus4.board, 32'h0);
    check("reset_move_count", 32'(bus4.move_count), 32'h0);
    check("reset_win", 32'(bus4.win), 32'h0);
    check("reset_busy", 32'(bus4.busy), 32'h0);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus4.sel = ev[i].sel;
      #1;
      check("error_flag", 32'(bus4.error), 32'(ev[i].err));
    end

    for (int i = 0; i < 5; i++) do_move(mv[i].sel, mv[i].n_row, mv[i].hold, mv[i].poke);

    d = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) d[(r*4+c)*2 +: 2] = (c == 2) ? 2'd2 : 2'd3;
    do_load(d);
    do_move(4'b0100, 1'b1, 1, 0);
    do_move(4'b0001, 1'b0, 1, 0);

    do_load(32'hFFFF_FFFF);
    do_move(4'b0001, 1'b0, 1, 0);

    @(negedge clk);
    bus4.sel = 4'b0010;
    bus4.n_row = 1'b1;
    bus4.fire = 1'b1;
    @(negedge clk);
    bus4.fire = 1'b0;
    @(negedge clk);
    check("busy_before_reset", 32'(bus4.busy), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("async_reset_board", bus4.board, 32'h0);
    check("async_reset_move_count", 32'(bus4.move_count), 32'h0);
    check("async_reset_busy", 32'(bus4.busy), 32'h0);
    check("async_reset_win", 32'(bus4.win), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    @(negedge clk);
    bus3.load_data = 32'h0000_00E7;
    bus3.load_en = 1'b1;
    bus3.sel = 4'b0001;
    bus3.n_row = 1'b0;
    bus3.fire = 1'b1;
    @(negedge clk);
    bus3.load_en = 1'b0;
    bus3.fire = 1'b0;
    bc = 0;
    for (int i = 0; i < 25; i++) begin
      if (bus3.busy) bc++;
      @(negedge clk);
    end
    check("load_fire_busy", 32'(bc), 32'h0);
    check("load_clip_board", bus3.board, 32'h0000_0024);
    check("load_clip_move_count", 32'(bus3.move_count), 32'h0);
    check("load_clip_win", 32'(bus3.win), 32'h0);

    bus3.fire = 1'b1;
    @(negedge clk);
    bus3.fire = 1'b0;
    repeat (25) @(negedge clk);
    check("ns3_wrap_board", bus3.board, 32'h0000_0049);
    check("ns3_move_count", 32'(bus3.move_count), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/board_engine.md
Name: board_engine

Overview:
- Parametrised N×N game-board core that replaces the hard-wired 4×4 cell array.
- Holds every cell's state and applies a "fire" move to one selected row or column. Each cell in that line steps modulo NSTATES.
- After each move it scans the board sequentially to detect a win, and it counts moves.
- Sits between the debounced switch/button inputs and the color decoder / display / audio path; the board bus keeps the existing row-major layout.

Parameters:
- N, 4, grid dimension (rows = columns), 2..8
- SW, 2, bits per cell state
- NSTATES, 4, number of cell states, 2..2^SW; need not be a power of two
- MOVE_W, 8, width of move counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- fire  in  1  debounced fire level; a rising edge is detected internally
- sel  in  N  one-hot row/column select from switches
- n_row  in  1  0 = sel addresses a row, 1 = sel addresses a column
- load_en  in  1  load board from load_data
- load_data  in  N*N*SW  board image; cell (r,c) at [(r*N+c)*SW +: SW]
- board  out  N*N*SW  current cell states, same layout
- error  out  1  sel not exactly one-hot (combinational)
- busy  out  1  move or scan in progress
- win  out  1  all cells equal after last completed move
- move_count  out  MOVE_W  accepted moves since reset/load, saturating

Behaviour:
- Reset (reset=0, asynchronous) forces the following; the FSM enters IDLE:
  - board = 0
  - move_count = 0
  - win = 0
  - busy = 0
  - internal fire_q = 0
  - scan/apply index = 0
- Edge detect: fire_q registers fire every cycle. A fire edge is (fire & ~fire_q). A held fire produces exactly one edge.
- FSM states: IDLE, APPLY, CHECK, DONE, WON.
- IDLE:
  - A fire edge with error=0 moves to APPLY. sel and n_row are latched, idx=0, move_count += 1 (saturating at all-ones).
  - A fire edge with error=1 is ignored; nothing changes.
- APPLY (N cycles, idx 0..N-1):
  - Updates one cell per cycle: (idx, selected col) for column mode, or (selected row, idx) for row mode.
  - Update rule: v = (v == NSTATES-1) ? 0 : v+1.
  - At idx = N-1, go to CHECK with k=1.
- CHECK (N*N-1 cycles, k = 1..N*N-1):
  - Each cycle compares cell k with cell 0 and ANDs the result into the eq flag (eq is set to 1 on APPLY exit).
  - At k = N*N-1, go to DONE.
- DONE (1 cycle): win <= eq. Next state is WON if eq, else IDLE.
- WON: win held at 1; fire edges ignored. Only load_en or reset leaves this state.
- busy = 1 in APPLY, CHECK and DONE. Busy duration is N*N+N cycles (20 for N=4), starting the cycle after the edge.
- Fire edges during busy are dropped, not queued.
- load_en is honoured only in IDLE or WON, and is ignored while busy. On load:
  - Board is loaded from load_data; any field >= NSTATES is stored as 0.
  - move_count = 0, win = 0, next state IDLE.
  - Load has priority over a simultaneous fire edge, and the edge is discarded.
- error = ~(sel != 0 && (sel & (sel-1)) == 0). It is purely combinational and does not depend on FSM state.
- Changes to sel/n_row during busy have no effect because the latched copies are used.
- The initial all-zero board is not reported as a win; win is only evaluated at DONE.

Optional Feature:
- Macro BOARD_DECREMENT_EN.
- Defined: adds input port add_n (1 bit), latched with sel at move acceptance.
  - add_n=1: each selected cell decrements, v = (v == 0) ? NSTATES-1 : v-1.
  - add_n=0: increment as above.
  - move_count still increments.
- Undefined: no add_n port; always increment.

Decomposition:
- Package board_pkg contains:
  - FSM state enum
  - cell_lsb(r,c,N,SW) index function
  - step_cell(v, dec, NSTATES) function
  - localparam for the CHECK length
- One natural sub-module: board_win_scanner (k counter, eq accumulator, done pulse), started by APPLY exit.

Test Plan:
- Reset mid-APPLY: drive reset=0 during APPLY → board = 0, move_count = 0, busy = 0 and win = 0 immediately, with no clock edge required.
- Row move: N=4, NSTATES=4, sel=4'b0010, n_row=0, fire pulse →
  - busy high for 20 cycles
  - board row 1 = 1, all other cells 0
  - move_count = 1, win = 0
- Wrap and win:
  - Setup: load all cells = 3 except column 2 = 2.
  - Move: sel=4'b0100, n_row=1, fire → column 2 = 3 and win = 1 at the end of DONE.
  - After win: next fire → no change, move_count unchanged.
  - Second wrap check: a later fire on a row of value 3 (after a reload) gives 0.
- Error: sel=4'b0110, fire → error = 1, busy stays 0, board and move_count unchanged. sel=4'b0000 → error = 1.
- Edge detect / busy drop:
  - fire held high 10 cycles → exactly one move (move_count = 1).
  - A second edge 5 cycles into busy → ignored, move_count stays 1.
- Load: load_data with a field = 3 and NSTATES=3, plus a simultaneous fire edge → field stored as 0, move_count = 0, no move applied.
